// File: rtl/burst_pkg.sv
// Shared types and constants for the burst assembler: FSM state encoding and
// the eight standard GSM 26-bit training sequences.
package burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_TAIL_HEAD = 3'd2,
    ST_DATA_A    = 3'd3,
    ST_TRAIN     = 3'd4,
    ST_DATA_B    = 3'd5,
    ST_TAIL_END  = 3'd6,
    ST_GUARD     = 3'd7
  } state_e;

  localparam int TRAIN_LEN = 26;

  // Element 0 is TSC0; each sequence is transmitted from bit 25 down to bit 0.
  localparam logic [0:7][25:0] TSC_TABLE = {
    26'h0970897, 26'h0B778B7, 26'h10EE90E, 26'h11ED11E,
    26'h06B906B, 26'h13AC13A, 26'h29F629F, 26'h3BC4BBC
  };

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for the modulator symbol request: a held-high request
// yields a single one-cycle edge.
module strobe_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic i_strobe,
  output logic o_edge
);

  logic r_strobe_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) r_strobe_q <= 1'b0;
    else          r_strobe_q <= i_strobe;
  end

  assign o_edge = i_strobe & ~r_strobe_q;

endmodule

// File: rtl/burst_assembler.sv
// Buffers one burst of payload bytes, then emits tails, data halves, training
// sequence and guard, one symbol per modulator request, optionally diff-encoded.
module burst_assembler
  import burst_pkg::*;
#(
  parameter int HALF_BYTES  = 7,
  parameter int TAIL_LEN    = 3,
  parameter int GUARD_LEN   = 8,
  parameter int DIFF_ENCODE = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [2:0] tsc_sel,
  input  logic       start,
  input  logic       abort,
  input  logic       symbol_input_strobe,
  output logic       current_symbol,
  output logic       armed,
  output logic       burst_active,
  output logic       burst_done
);

  localparam int NBYTES    = 2 * HALF_BYTES;
  localparam int DATA_BITS = 8 * HALF_BYTES;
  localparam int BIW       = $clog2(NBYTES);
  localparam int WCW       = $clog2(NBYTES + 1);

  state_e           r_state;
  logic [WCW-1:0]   r_wr_count;
  logic [7:0]       r_buf [NBYTES];
  logic [7:0]       r_sym_cnt;
  logic [2:0]       r_tsc;
  logic             r_prev_bit;
  logic             r_symbol;
  logic             r_done;

  logic             w_edge;
  logic             w_wr_en;
  logic             w_bit;
  logic [7:0]       w_seg_len;
  state_e           w_next_state;
  logic [BIW-1:0]   w_byte_idx;
  logic [4:0]       w_train_idx;

  strobe_edge_detect u_strobe_edge (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_strobe (symbol_input_strobe),
    .o_edge   (w_edge)
  );

  assign wr_ready       = (r_state == ST_IDLE) && (r_wr_count < WCW'(NBYTES));
  assign w_wr_en        = wr_valid && wr_ready;
  assign armed          = (r_state == ST_ARMED);
  assign burst_active   = (r_state != ST_IDLE) && (r_state != ST_ARMED);
  assign current_symbol = r_symbol;
  assign burst_done     = r_done;

  assign w_byte_idx  = BIW'(r_sym_cnt[7:3]) + ((r_state == ST_DATA_B) ? BIW'(HALF_BYTES) : '0);
  assign w_train_idx = 5'(TRAIN_LEN - 1) - r_sym_cnt[4:0];

  // Raw bit b for the current position, segment length and successor segment.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_bit        = 1'b1;
    w_seg_len    = 8'(GUARD_LEN);
    w_next_state = ST_IDLE;
    case (r_state)
      ST_TAIL_HEAD: begin
        w_bit = 1'b0; w_seg_len = 8'(TAIL_LEN); w_next_state = ST_DATA_A;
      end
      ST_DATA_A: begin
        w_bit = r_buf[w_byte_idx][r_sym_cnt[2:0]]; w_seg_len = 8'(DATA_BITS); w_next_state = ST_TRAIN;
      end
      ST_TRAIN: begin
        w_bit = TSC_TABLE[r_tsc][w_train_idx]; w_seg_len = 8'(TRAIN_LEN); w_next_state = ST_DATA_B;
      end
      ST_DATA_B: begin
        w_bit = r_buf[w_byte_idx][r_sym_cnt[2:0]]; w_seg_len = 8'(DATA_BITS); w_next_state = ST_TAIL_END;
      end
      ST_TAIL_END: begin
        w_bit = 1'b0; w_seg_len = 8'(TAIL_LEN); w_next_state = ST_GUARD;
      end
      default: ;
    endcase
  end

  // NOTE: the payload array has no reset; its contents are meaningless until
  // rewritten, and wr_count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_buf[r_wr_count[BIW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_wr_count <= '0;
      r_sym_cnt  <= '0;
      r_tsc      <= '0;
      r_prev_bit <= 1'b1;
      r_symbol   <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= ST_IDLE;
        r_wr_count <= '0;
        r_prev_bit <= 1'b1;
        r_symbol   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_wr_en)                          r_wr_count <= r_wr_count + 1'b1;
            else if (r_wr_count == WCW'(NBYTES)) r_state    <= ST_ARMED;
          end
          ST_ARMED: begin
            if (start) begin
              r_tsc      <= tsc_sel;
              r_sym_cnt  <= '0;
              r_prev_bit <= 1'b1;
              r_state    <= ST_TAIL_HEAD;
            end
          end
          ST_GUARD: begin
            // One edge beyond the last guard symbol closes the burst.
            if (w_edge) begin
              r_symbol   <= 1'b1;
              r_prev_bit <= 1'b1;
              if (r_sym_cnt == 8'(GUARD_LEN)) begin
                r_done     <= 1'b1;
                r_wr_count <= '0;
                r_state    <= ST_IDLE;
              end else begin
                r_sym_cnt <= r_sym_cnt + 8'd1;
              end
            end
          end
          default: begin
            if (w_edge) begin
              r_symbol   <= (DIFF_ENCODE != 0) ? (w_bit ^ r_prev_bit) : w_bit;
              r_prev_bit <= w_bit;
              if (r_sym_cnt == w_seg_len - 8'd1) begin
                r_sym_cnt <= '0;
                r_state   <= w_next_state;
              end else begin
                r_sym_cnt <= r_sym_cnt + 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/burst_assembler.md
Name: burst_assembler

Overview:
- Upstream stage of tx_burst.
- Buffers one burst of payload bytes, then builds the over-the-air symbol sequence: head tail, data half A, training sequence, data half B, end tail, guard.
- Presents one symbol per modulator symbol request (symbol_input_strobe) on current_symbol; tx_burst forwards this to the GMSK modulator.
- Optional GSM-style differential encoding is applied at the output.

Parameters:
- HALF_BYTES, 7, payload bytes per data half (56 bits each half).
- TAIL_LEN, 3, tail symbols at the head and at the end.
- GUARD_LEN, 8, guard symbols after the end tail.
- DIFF_ENCODE, 1, 1 = output d_i = b_i XOR b_(i-1); 0 = raw bits.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  payload byte valid.
- wr_data  in  8  payload byte.
- wr_ready  out  1  buffer accepts a byte this cycle.
- tsc_sel  in  3  training sequence index, sampled at start.
- start  in  1  begin a burst; honoured only while armed.
- abort  in  1  kill the burst in progress.
- symbol_input_strobe  in  1  modulator symbol request (level; may be high for several cycles).
- current_symbol  out  1  symbol to modulate.
- armed  out  1  buffer full, awaiting start.
- burst_active  out  1  burst in progress.
- burst_done  out  1  one-cycle pulse at burst completion.

Behaviour:
Reset:
- Reset is synchronous, active-low, on clock.
- reset_n low gives: state IDLE, wr_count 0, current_symbol 1, armed 0, burst_active 0, burst_done 0, prev_bit 1.
- Reset mid-burst behaves the same: it discards buffer contents and gives no done pulse.

Strobe handling:
- strobe_edge = symbol_input_strobe high AND its registered copy low.
- Only edges advance symbols; a held-high strobe advances exactly once.

Payload buffer:
- Buffer of 2*HALF_BYTES bytes.
- wr_ready = (state==IDLE) AND (wr_count < 2*HALF_BYTES).
- A byte is written when wr_valid AND wr_ready; wr_count increments.
- When wr_count reaches 2*HALF_BYTES the FSM goes to ARMED on the next cycle.
- Writes outside IDLE are ignored and not acknowledged.

FSM states:
- IDLE: loading; current_symbol held 1.
- ARMED: armed=1; current_symbol held 1.
  - start=1 latches tsc_sel, clears symbol index and prev_bit (to 1), sets burst_active=1, goes to TAIL_HEAD.
  - start outside ARMED is ignored.
- TAIL_HEAD: TAIL_LEN symbols, all bits b=0.
- DATA_A: bytes 0..HALF_BYTES-1, each byte sent LSB first.
- TRAIN: 26 bits from TSC_TABLE[tsc_latched], bit 25 first.
- DATA_B: bytes HALF_BYTES..2*HALF_BYTES-1, LSB first.
- TAIL_END: TAIL_LEN symbols, b=0.
- GUARD: GUARD_LEN symbols, b=1.
  - Differential encoding is bypassed in GUARD: output is 1 regardless of DIFF_ENCODE.

Symbol timing:
- Each strobe_edge in a burst state registers the next symbol into current_symbol; it is valid the cycle after the edge.
- State, byte and bit counters advance on the same edge.
- The first edge after start outputs tail symbol 0.
- The strobe_edge following the last guard symbol:
  - leaves current_symbol at 1;
  - pulses burst_done for one cycle;
  - clears burst_active and wr_count;
  - returns to IDLE.
- Total symbols per burst with defaults: 3+56+26+56+3+8 = 152.

Differential encoding:
- With DIFF_ENCODE=1, output = b XOR prev_bit, then prev_bit <= b.
- prev_bit = 1 at burst start.

Abort:
- abort=1 in any burst state goes to IDLE next cycle.
- current_symbol=1, burst_active=0, wr_count=0, no burst_done.
- abort in IDLE/ARMED also clears wr_count and returns to IDLE.

Simultaneous events:
- abort beats start.
- A strobe_edge on the cycle start is accepted is ignored; the first symbol comes on the next edge.
- reset_n beats everything.

Decomposition:
- Package burst_pkg holds:
  - state enum;
  - TSC_TABLE, the eight standard GSM 26-bit training sequences (TSC0 = 26'h0970897);
  - TRAIN_LEN = 26.
- One sub-module, strobe_edge_detect: registered rising-edge detector on symbol_input_strobe.
  - tx_burst will adopt it later in place of its lockout logic.

Test Plan:
- Load bytes 0x00 x14, tsc_sel=0, DIFF_ENCODE=0, start, then strobe pulses every 5 clocks:
  - armed rises after the 14th write;
  - symbols = 59 zeros, 0010010111000010001001 0111, 59 zeros, 8 ones;
  - burst_done once after edge 153.
- Same run with DIFF_ENCODE=1:
  - first symbol 1 (0 XOR prev 1), then 58 zeros;
  - first training output = 0 XOR 0 = 0;
  - guard all 1.
- Data 0x01,0x80 then 0x00 x12, DIFF_ENCODE=0:
  - DATA_A symbols = 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1, then zeros.
- Hold symbol_input_strobe high 12 cycles per request: exactly one symbol advance per request; total still 152.
- Assert abort at symbol 70:
  - next cycle current_symbol=1, burst_active=0, wr_ready=1, wr_count=0;
  - no burst_done.
- Pulse start during loading (wr_count=5): ignored, burst_active stays 0.
- Drop reset_n for 1 cycle mid-DATA_B: all outputs return to reset values; wr_ready=1.
